// File: rtl/seq_divider_pkg.sv
// div_pkg: shared types and constants for the sequential divider.
//   state_t      - FSM encoding (IDLE / RUN / FIN)
//   MAX_WIDTH    - widest legal operand width
//   DZ_QUOTIENT  - quotient reported on divide-by-zero (all ones, sliced to WIDTH)
//   cnt_width()  - bits needed for the step counter, which holds WIDTH-1 down to 0
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 25;

  localparam logic [MAX_WIDTH-1:0] DZ_QUOTIENT = '1;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_divider_sub_cla.sv
// sub_cla: combinational N-bit carry-lookahead subtractor, diff = a - b.
// Computed as a + ~b + 1, so generate/propagate are taken against ~b.
//   a, b      - N-bit unsigned operands
//   diff      - N-bit difference (p ^ c)
//   no_borrow - carry out; 1 when a >= b
// Group carries are looked ahead in 4-bit blocks; the carries inside a block
// are expanded from that block's carry-in.
module sub_cla #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         no_borrow
);

  // Only full 4-bit groups need a lookahead carry; a partial top group is
  // expanded from the last full group's carry.
  localparam int NGF = N / 4;

  logic [N-1:0] g, p;
  logic [N:0]   c;
  logic [NGF:0] cgv;
  logic [3:0]   gg, pg;
  logic         cj;

  always_comb begin
    g   = a & ~b;
    p   = a ~^ b;
    gg  = '0;
    pg  = '0;
    cgv = '0;
    cgv[0] = 1'b1;
    for (int k = 0; k < NGF; k++) begin
      gg = g[4*k +: 4];
      pg = p[4*k +: 4];
      cgv[k+1] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
               | (pg[3] & pg[2] & pg[1] & gg[0]) | ((&pg) & cgv[k]);
    end
    c  = '0;
    cj = 1'b0;
    for (int j = 0; j <= N; j++) begin
      cj = cgv[j/4];
      for (int i = 4*(j/4); i < j; i++) cj = g[i] | (p[i] & cj);
      c[j] = cj;
    end
    diff      = p ^ c[N-1:0];
    no_borrow = c[N];
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, one quotient bit per clock.
//   clk, rst     - clock (rising edge), synchronous active-high reset
//   start        - request, accepted in IDLE or FIN
//   dividend     - numerator, captured on accept
//   divisor      - denominator, captured on accept
//   busy         - high while stepping (RUN)
//   done         - one-cycle pulse in FIN; results valid from this cycle
//   quotient     - result quotient, held until the next done
//   remainder    - result remainder, held until the next done
//   div_by_zero  - set with done when divisor was 0, held until next accept
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_reg, d_reg;
  logic [WIDTH:0]   r_reg;
  logic [CW-1:0]    cnt;
  logic             accept;

  logic [WIDTH:0]   sub_a, sub_b, sub_diff, r_next;
  logic             no_borrow;
  logic [WIDTH-1:0] q_next;

  assign accept = start & ((state == IDLE) | (state == FIN));

  // Trial subtract of the shifted partial remainder against the divisor.
  assign sub_a = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign sub_b = {1'b0, d_reg};

  sub_cla #(.N(WIDTH+1)) u_sub (
    .a         (sub_a),
    .b         (sub_b),
    .diff      (sub_diff),
    .no_borrow (no_borrow)
  );

  assign r_next = no_borrow ? sub_diff : sub_a;
  assign q_next = {q_reg[WIDTH-2:0], no_borrow};

  // R < D always holds, so the stored top bit of R is always zero and never
  // feeds the next step.
  logic unused_r_msb;
  assign unused_r_msb = r_reg[WIDTH];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: begin
        if (accept) state_nxt = (divisor != '0) ? RUN : FIN;
        else        state_nxt = IDLE;
      end
      RUN:     if (cnt == '0) state_nxt = FIN;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state == RUN);
    done = (state == FIN);
  end

  // Datapath. Results land on the edge entering FIN so they are already valid
  // in the done cycle and simply hold afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      q_reg       <= dividend;
      d_reg       <= divisor;
      r_reg       <= '0;
      cnt         <= CW'(WIDTH-1);
      div_by_zero <= (divisor == '0);
      if (divisor == '0) begin
        quotient  <= DZ_QUOTIENT[WIDTH-1:0];
        remainder <= dividend;
      end
    end else if (state == RUN) begin
      q_reg <= q_next;
      r_reg <= r_next;
      cnt   <= cnt - 1'b1;
      if (cnt == '0) begin
        quotient  <= q_next;
        remainder <= r_next[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Present operands before an edge; on return we are just past the accept edge (cycle 0).
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count negedges until done; lat=0 means it never came within the budget.
  task automatic wait_done(output int lat, output int nbusy);
    lat = 0; nbusy = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0)        begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    if (quotient !== 8'd0)    begin errors++; $display("FAIL reset_q: got %0d expected 0", quotient); end
    if (remainder !== 8'd0)   begin errors++; $display("FAIL reset_r: got %0d expected 0", remainder); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b expected 0", div_by_zero); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    start_op(8'd200, 8'd7);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks += 2;
      if (busy !== (i <= 8)) begin errors++; $display("FAIL basic_busy c%0d: got %b expected %b", i, busy, (i <= 8)); end
      if (done !== (i == 9)) begin errors++; $display("FAIL basic_done c%0d: got %b expected %b", i, done, (i == 9)); end
      if (i == 9) begin
        checks += 3;
        if (quotient !== 8'd28)   begin errors++; $display("FAIL basic_q: got %0d expected 28", quotient); end
        if (remainder !== 8'd4)   begin errors++; $display("FAIL basic_r: got %0d expected 4", remainder); end
        if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dz: got %b expected 0", div_by_zero); end
      end
    end
    checks++;
    if (quotient !== 8'd28) begin errors++; $display("FAIL basic_hold: got %0d expected 28", quotient); end
  endtask

  task automatic test_boundaries();
    logic [7:0] va [6] = '{8'd255, 8'd5, 8'd255, 8'd0,  8'd128, 8'd254};
    logic [7:0] vb [6] = '{8'd1,   8'd9, 8'd255, 8'd13, 8'd1,   8'd255};
    logic [7:0] vq [6] = '{8'd255, 8'd0, 8'd1,   8'd0,  8'd128, 8'd0};
    logic [7:0] vr [6] = '{8'd0,   8'd5, 8'd0,   8'd0,  8'd0,   8'd254};
    int lat, nb;
    for (int k = 0; k < 6; k++) begin
      start_op(va[k], vb[k]);
      wait_done(lat, nb);
      checks += 4;
      if (lat != 9)              begin errors++; $display("FAIL bnd_lat %0d/%0d: got %0d expected 9", va[k], vb[k], lat); end
      if (quotient !== vq[k])    begin errors++; $display("FAIL bnd_q %0d/%0d: got %0d expected %0d", va[k], vb[k], quotient, vq[k]); end
      if (remainder !== vr[k])   begin errors++; $display("FAIL bnd_r %0d/%0d: got %0d expected %0d", va[k], vb[k], remainder, vr[k]); end
      if (div_by_zero !== 1'b0)  begin errors++; $display("FAIL bnd_dz %0d/%0d: got %b expected 0", va[k], vb[k], div_by_zero); end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    int lat, nb;
    start_op(8'd100, 8'd0);
    wait_done(lat, nb);
    checks += 5;
    if (lat != 1)             begin errors++; $display("FAIL dz_lat: got %0d expected 1", lat); end
    if (nb != 0)              begin errors++; $display("FAIL dz_busy: got %0d busy cycles expected 0", nb); end
    if (quotient !== 8'd255)  begin errors++; $display("FAIL dz_q: got %0d expected 255", quotient); end
    if (remainder !== 8'd100) begin errors++; $display("FAIL dz_r: got %0d expected 100", remainder); end
    if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", div_by_zero); end
    repeat (3) @(negedge clk);
    checks++;
    if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_hold: got %b expected 1", div_by_zero); end
    start_op(8'd9, 8'd3);
    @(negedge clk);
    checks += 3;
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_clear: got %b expected 0", div_by_zero); end
    if (quotient !== 8'd255)  begin errors++; $display("FAIL dz_qhold: got %0d expected 255", quotient); end
    if (remainder !== 8'd100) begin errors++; $display("FAIL dz_rhold: got %0d expected 100", remainder); end
    // Cycle 1 already consumed, so done is 8 more negedges away.
    wait_done(lat, nb);
    checks += 3;
    if (lat != 8)           begin errors++; $display("FAIL dz_next_lat: got %0d expected 8", lat); end
    if (quotient !== 8'd3)  begin errors++; $display("FAIL dz_next_q: got %0d expected 3", quotient); end
    if (remainder !== 8'd0) begin errors++; $display("FAIL dz_next_r: got %0d expected 0", remainder); end
  endtask

  task automatic test_busy_ignore();
    int done_at = 0;
    start_op(8'd77, 8'd5);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done && done_at == 0) done_at = i;
      if (i == 2) begin dividend = 8'd0;  divisor = 8'd0; end
      if (i == 3) begin start = 1'b1; dividend = 8'd10; divisor = 8'd2; end
      if (i == 4) start = 1'b0;
      if (i == 9) begin
        checks += 2;
        if (quotient !== 8'd15) begin errors++; $display("FAIL ign_q: got %0d expected 15", quotient); end
        if (remainder !== 8'd2) begin errors++; $display("FAIL ign_r: got %0d expected 2", remainder); end
      end
      if (i > 9) begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          errors++; $display("FAIL ign_requeue c%0d: got busy=%b done=%b expected 0 0", i, busy, done);
        end
      end
    end
    checks++;
    if (done_at != 9) begin errors++; $display("FAIL ign_lat: got %0d expected 9", done_at); end
  endtask

  task automatic test_back_to_back();
    int lat, nb;
    start_op(8'd200, 8'd7);
    wait_done(lat, nb);
    checks += 2;
    if (lat != 9)           begin errors++; $display("FAIL b2b_lat1: got %0d expected 9", lat); end
    if (quotient !== 8'd28) begin errors++; $display("FAIL b2b_q1: got %0d expected 28", quotient); end
    // Still in the FIN cycle: request the next op right now.
    start = 1'b1; dividend = 8'd64; divisor = 8'd8;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, nb);
    checks += 4;
    if (lat != 9)           begin errors++; $display("FAIL b2b_lat2: got %0d expected 9", lat); end
    if (nb != 8)            begin errors++; $display("FAIL b2b_gap: got %0d busy cycles expected 8", nb); end
    if (quotient !== 8'd8)  begin errors++; $display("FAIL b2b_q2: got %0d expected 8", quotient); end
    if (remainder !== 8'd0) begin errors++; $display("FAIL b2b_r2: got %0d expected 0", remainder); end
  endtask

  task automatic test_reset_mid_run();
    int lat, nb;
    int spurious = 0;
    start_op(8'd123, 8'd4);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 4;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rr_state: got busy=%b done=%b expected 0 0", busy, done); end
    if (quotient !== 8'd0)    begin errors++; $display("FAIL rr_q: got %0d expected 0", quotient); end
    if (remainder !== 8'd0)   begin errors++; $display("FAIL rr_r: got %0d expected 0", remainder); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL rr_dz: got %b expected 0", div_by_zero); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    checks++;
    if (spurious != 0) begin errors++; $display("FAIL rr_no_done: got %0d active cycles expected 0", spurious); end
    start_op(8'd123, 8'd4);
    wait_done(lat, nb);
    checks += 3;
    if (lat != 9)           begin errors++; $display("FAIL rr_lat: got %0d expected 9", lat); end
    if (quotient !== 8'd30) begin errors++; $display("FAIL rr_q2: got %0d expected 30", quotient); end
    if (remainder !== 8'd3) begin errors++; $display("FAIL rr_r2: got %0d expected 3", remainder); end
  endtask

  task automatic test_random();
    int lat, nb, exp_lat;
    logic [7:0] a, b, eq, er;
    logic edz;
    for (int n = 0; n < 2000; n++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (b == 8'd0) begin eq = 8'd255; er = a; edz = 1'b1; exp_lat = 1; end
      else           begin eq = a / b;  er = a % b; edz = 1'b0; exp_lat = 9; end
      start_op(a, b);
      wait_done(lat, nb);
      checks += 4;
      if (lat != exp_lat)     begin errors++; $display("FAIL rnd_lat %0d/%0d: got %0d expected %0d", a, b, lat, exp_lat); end
      if (quotient !== eq)    begin errors++; $display("FAIL rnd_q %0d/%0d: got %0d expected %0d", a, b, quotient, eq); end
      if (remainder !== er)   begin errors++; $display("FAIL rnd_r %0d/%0d: got %0d expected %0d", a, b, remainder, er); end
      if (div_by_zero !== edz) begin errors++; $display("FAIL rnd_dz %0d/%0d: got %b expected %b", a, b, div_by_zero, edz); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
